// File: rtl/guitar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | guitar_pkg                                                           |
// | Note encoding and half-period table shared by the string voices.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package guitar_pkg;

    typedef enum logic [2:0] {
        NOTE_A    = 3'd0,
        NOTE_B    = 3'd1,
        NOTE_C    = 3'd2,
        NOTE_D    = 3'd3,
        NOTE_E    = 3'd4,
        NOTE_F    = 3'd5,
        NOTE_G    = 3'd6,
        NOTE_MUTE = 3'd7
    } note_t;

    localparam int unsigned CLK_HZ = 25_000_000;

    // Half period in clocks at CLK_HZ; MUTE has no tone and maps to 0.
    function automatic logic [15:0] half_period(input note_t n);
        logic [15:0] hp;
        case (n)
            NOTE_A:  hp = 16'd56818;
            NOTE_B:  hp = 16'd50607;
            NOTE_C:  hp = 16'd47892;
            NOTE_D:  hp = 16'd42517;
            NOTE_E:  hp = 16'd37878;
            NOTE_F:  hp = 16'd35816;
            NOTE_G:  hp = 16'd31887;
            default: hp = 16'd0;
        endcase
        return hp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/string_voice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | string_voice                                                         |
// | One plucked string: square-wave phase counter and linear envelope.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module string_voice
    import guitar_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int AMP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 strum,
    input  logic [2:0]           note,
    input  logic                 tick,
    output logic                 active,
    output logic [AMP_WIDTH-1:0] sample
);

    localparam logic [AMP_WIDTH-1:0] c_AMP_MAX = '1;

    logic [2:0]           r_note;
    logic [DIV_WIDTH-1:0] r_phase;
    logic                 r_wave;
    logic [AMP_WIDTH-1:0] r_amp;
    logic [2:0]           w_note_eff;
    logic [DIV_WIDTH-1:0] w_reload;

    // A strum reloads from the incoming note, otherwise the latched one.
    assign w_note_eff = strum ? note : r_note;
    assign w_reload   = DIV_WIDTH'(half_period(note_t'(w_note_eff))) - DIV_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note  <= '0;
            r_phase <= '0;
            r_wave  <= 1'b0;
            r_amp   <= '0;
        end else if (strum) begin
            r_note <= note;
            if (note != NOTE_MUTE) begin
                r_amp   <= c_AMP_MAX;
                r_wave  <= 1'b1;
                r_phase <= w_reload;
            end else begin
                r_amp <= '0;
            end
        end else if (r_amp != '0) begin
            if (r_phase == '0) begin
                r_phase <= w_reload;
                r_wave  <= ~r_wave;
            end else begin
                r_phase <= r_phase - DIV_WIDTH'(1);
            end
            if (tick) begin
                r_amp <= r_amp - AMP_WIDTH'(1);
            end
        end
    end

    assign active = (r_amp != '0);
    assign sample = r_wave ? r_amp : '0;

endmodule
`default_nettype wire

// File: rtl/string_voice_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | string_voice_bank                                                    |
// | Polyphonic string voices, mixer and first-order sigma-delta output. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module string_voice_bank
    import guitar_pkg::*;
#(
    parameter  int NUM_VOICES  = 6,
    parameter  int DIV_WIDTH   = 16,
    parameter  int AMP_WIDTH   = 8,
    parameter  int DECAY_TICKS = 25000,
    localparam int SUM_W       = AMP_WIDTH + $clog2(NUM_VOICES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_VOICES-1:0]   strum,
    input  logic [3*NUM_VOICES-1:0] note_sel,
    output logic [NUM_VOICES-1:0]   active,
    output logic [SUM_W-1:0]        mix,
    output logic                    audio_out
);

    localparam int              c_PRE_W    = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(DECAY_TICKS - 1);

    logic [c_PRE_W-1:0]   r_pre;
    logic                 w_tick;
    logic [AMP_WIDTH-1:0] w_sample [NUM_VOICES];
    logic [SUM_W-1:0]     w_sum;
    logic [SUM_W-1:0]     r_mix;
    logic [SUM_W:0]       r_acc;

    assign w_tick = (r_pre == c_PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        string_voice #(
            .DIV_WIDTH(DIV_WIDTH),
            .AMP_WIDTH(AMP_WIDTH)
        ) u_voice (
            .clk    (clk),
            .rst_n  (rst_n),
            .strum  (strum[gi]),
            .note   (note_sel[3*gi +: 3]),
            .tick   (w_tick),
            .active (active[gi]),
            .sample (w_sample[gi])
        );
    end

    // SUM_W is sized so the full-scale sum of all voices cannot overflow.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_sum = w_sum + SUM_W'(w_sample[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mix <= '0;
            r_acc <= '0;
        end else begin
            r_mix <= w_sum;
            r_acc <= {1'b0, r_acc[SUM_W-1:0]} + {1'b0, r_mix};
        end
    end

    assign mix       = r_mix;
    assign audio_out = r_acc[SUM_W];

endmodule
`default_nettype wire

// File: tb/tb_string_voice_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_string_voice_bank                                                 |
// | Randomized self-checking bench with a closed-form voice model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_string_voice_bank;

    localparam int NV   = 6;
    localparam int DT   = 200;
    localparam int SW   = 11;
    localparam int AMAX = 255;
    localparam int FS   = 2048;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [NV-1:0] strum    = '0;
    logic [3*NV-1:0] note_sel = '0;
    logic [NV-1:0] active;
    logic [SW-1:0] mix;
    logic          audio_out;

    string_voice_bank #(
        .NUM_VOICES  (NV),
        .DIV_WIDTH   (16),
        .AMP_WIDTH   (8),
        .DECAY_TICKS (DT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strum     (strum),
        .note_sel  (note_sel),
        .active    (active),
        .mix       (mix),
        .audio_out (audio_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k;
    int hp [7] = '{56818, 50607, 47892, 42517, 37878, 35816, 31887};

    // Model: each voice is described by the edge it was struck on and its note.
    int vs [NV];
    int vn [NV];
    int pv [NV];
    int ps [NV];
    int pn [NV];
    int sum_prev, mix_prev, acc_prev, m_mixin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, k);
        end
    endtask

    // Ticks fall on edges that are multiples of DT counted from reset release.
    function automatic int m_amp(input int i, input int kk);
        int a;
        if (vn[i] == 7) return 0;
        a = AMAX - (kk / DT - vs[i] / DT);
        return (a < 0) ? 0 : a;
    endfunction

    function automatic bit m_wave(input int i, input int kk);
        return (((kk - vs[i]) / hp[vn[i]]) % 2) == 0;
    endfunction

    always @(negedge clk) begin : p_cmp
        int cur, emix, eacc, a;
        logic [NV-1:0] eact;
        if (!rst_n) begin
            for (int i = 0; i < NV; i++) begin
                vn[i] = 7; vs[i] = 0; pv[i] = 0;
            end
            sum_prev = 0; mix_prev = 0; acc_prev = 0; m_mixin = 0;
            chk("rst_mix", 32'(mix), 0);
            chk("rst_active", 32'(active), 0);
            chk("rst_audio", 32'(audio_out), 0);
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (pv[i] != 0 && ps[i] == k) begin
                    vs[i] = ps[i]; vn[i] = pn[i]; pv[i] = 0;
                end
            end
            cur = 0; eact = '0;
            for (int i = 0; i < NV; i++) begin
                a = m_amp(i, k);
                if (a != 0) begin
                    eact[i] = 1'b1;
                    if (m_wave(i, k)) cur += a;
                end
            end
            emix    = sum_prev;
            eacc    = (acc_prev % FS) + mix_prev;
            m_mixin = mix_prev;
            chk("mix", 32'(mix), emix);
            chk("active", 32'(active), 32'(eact));
            chk("audio_out", 32'(audio_out), (eacc >= FS) ? 1 : 0);
            mix_prev = emix; acc_prev = eacc; sum_prev = cur;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        strum = '0;
    endtask

    task automatic pluck(input int i, input int n);
        note_sel[3*i +: 3] = 3'(n);
        strum[i] = 1'b1;
        pv[i] = 1; ps[i] = k + 1; pn[i] = n;
    endtask

    initial begin : p_stim
        int ones, msum, dexp, s0, s2, fall, c, n;
        bit done, retrig, fell;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle after reset: nothing may sound.
        repeat (10000) step();
        chk("idle_mix", 32'(mix), 0);
        chk("idle_active", 32'(active), 0);
        chk("idle_audio", 32'(audio_out), 0);

        // Short random plucks on random voices, then mute everything.
        repeat (40) begin
            n = $urandom_range(0, 7);
            pluck($urandom_range(0, NV-1), n);
            repeat ($urandom_range(1, 60)) step();
        end
        for (int i = 0; i < NV; i++) pluck(i, 7);
        repeat (3) step();

        // All voices on G in the same cycle.
        for (int i = 0; i < NV; i++) pluck(i, 6);
        step();
        step();
        chk("allG_mix", 32'(mix), 1530);
        chk("allG_active", 32'(active), 32'h3f);
        ones = 0; msum = 0;
        repeat (FS) begin
            @(negedge clk); #1;
            ones += audio_out;
            msum += m_mixin;
        end
        dexp = msum / FS;
        checks++;
        if (!(ones >= dexp && ones <= dexp + 1)) begin
            errors++;
            $display("FAIL density: ones %0d required %0d..%0d", ones, dexp, dexp + 1);
        end
        step();
        for (int i = 0; i < NV; i++) pluck(i, 7);
        repeat (3) step();
        chk("mute_all_mix", 32'(mix), 0);
        chk("mute_all_active", 32'(active), 0);

        // Strum landing on a tick edge must load full amplitude.
        c = 0;
        while (((k + 1) % DT) != 0 && c < DT + 2) begin
            step();
            c++;
        end
        pluck(3, 0);
        step();
        chk("tickstrum_active", 32'(active), 32'h08);
        step();
        chk("tickstrum_mix", 32'(mix), 255);
        pluck(3, 7);
        step();
        chk("mute_active", 32'(active), 0);

        // Long decay on voices 0/1/2; retrigger voice 2 on C at amplitude 100.
        pluck(0, 0); pluck(1, 6); pluck(2, 0);
        s0 = k + 1; s2 = 0;
        done = 0; retrig = 0; fell = 0;
        for (int i = 0; i < 90000 && !done; i++) begin
            step();
            if (!fell && k > s0 && !active[0]) begin
                fell = 1;
                fall = k - s0;
                checks++;
                if (!(fall >= AMAX*DT - DT && fall <= AMAX*DT + DT)) begin
                    errors++;
                    $display("FAIL decay_len: got %0d required %0d +- %0d", fall, AMAX*DT, DT);
                end
            end
            if (!retrig && k > s0 && m_amp(2, k) == 100) begin
                pluck(2, 2);
                s2 = k + 1;
                retrig = 1;
            end
            if (retrig && k >= s2 + 47892 + 3) done = 1;
        end
        if (!done || !fell) chk("decay_phase_timeout", 0, 1);
        chk("retrig_still_active", 32'(active[2]), 1);

        // Asynchronous reset between edges while a note is sounding.
        pluck(4, 0);
        step();
        step();
        chk("pre_reset_active4", 32'(active[4]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_mix", 32'(mix), 0);
        chk("async_rst_active", 32'(active), 0);
        chk("async_rst_audio", 32'(audio_out), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (50) step();
        chk("post_reset_mix", 32'(mix), 0);
        chk("post_reset_active", 32'(active), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
